// File: rtl/audio_codec_slave.sv
// Codec-side endpoint of the 16-bit left-justified audio link: deserialises DACDAT
// into L/R pairs and serialises a double-buffered ADC pair onto ADCDAT.
module audio_codec_slave #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 32
) (
    input  logic                  BCLK,
    input  logic                  iRST_N,
    input  logic                  iLRCK,
    input  logic                  iDACDAT,
    output logic                  oADCDAT,
    input  logic [DATA_WIDTH-1:0] iADC_L,
    input  logic [DATA_WIDTH-1:0] iADC_R,
    input  logic                  iADC_WR,
    output logic                  oADC_RDY,
    output logic                  oADC_UNDERRUN,
    output logic [DATA_WIDTH-1:0] oDAC_L,
    output logic [DATA_WIDTH-1:0] oDAC_R,
    output logic                  oDAC_VALID,
    output logic                  oSLOT_ERR
);

    localparam int CNT_W = $clog2(SLOT_BITS + 1);
    localparam int TXC_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_BITS);
    localparam logic [TXC_W-1:0] TXC_WORD = TXC_W'(DATA_WIDTH);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  lrck_q, lrck_d;
    logic                  primed_q, primed_d;
    logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pend_l_q, pend_l_d;
    logic                  left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0] dac_l_q, dac_l_d;
    logic [DATA_WIDTH-1:0] dac_r_q, dac_r_d;
    logic                  dac_valid_q, dac_valid_d;
    logic                  slot_err_q, slot_err_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic                  adcdat_q, adcdat_d;
    logic [TXC_W-1:0]      txcnt_q, txcnt_d;

    logic                  lrck_edge;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [DATA_WIDTH-1:0] tx_shifted;

    // primed_q masks the bogus edge seen on the first posedge after reset,
    // when lrck_q still holds its reset value rather than the real LRCK level.
    always_comb begin
        lrck_edge   = primed_q && (iLRCK != lrck_q);
        word        = {shift_q, iDACDAT};
        xfer        = 1'b0;
        lrck_d      = iLRCK;
        primed_d    = 1'b1;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        pend_l_d    = pend_l_q;
        left_ok_d   = left_ok_q;
        dac_l_d     = dac_l_q;
        dac_r_d     = dac_r_q;
        dac_valid_d = 1'b0;
        slot_err_d  = 1'b0;
        underrun_d  = 1'b0;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;

        case (state_q)
            ST_SYNC: begin
                if (lrck_edge) begin
                    state_d  = iLRCK ? ST_LEFT : ST_RIGHT;
                    shift_d  = word[DATA_WIDTH-2:0];
                    bitcnt_d = CNT_W'(1);
                end
            end
            default: begin
                if (lrck_edge) begin
                    if (bitcnt_q < CNT_WORD) begin
                        slot_err_d = 1'b1;
                        if (state_q == ST_LEFT) left_ok_d = 1'b0;
                    end
                    state_d  = iLRCK ? ST_LEFT : ST_RIGHT;
                    shift_d  = word[DATA_WIDTH-2:0];
                    bitcnt_d = CNT_W'(1);
                end else begin
                    if (bitcnt_q < CNT_WORD) shift_d = word[DATA_WIDTH-2:0];
                    if (bitcnt_q < CNT_SAT)  bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_LAST) begin
                        if (state_q == ST_LEFT) begin
                            pend_l_d  = word;
                            left_ok_d = 1'b1;
                        end else begin
                            xfer = 1'b1;
                            if (left_ok_q) begin
                                dac_l_d     = pend_l_q;
                                dac_r_d     = word;
                                dac_valid_d = 1'b1;
                            end
                            left_ok_d = 1'b0;
                        end
                    end
                end
            end
        endcase

        // A write landing on a transfer with the holding register full is
        // dropped; with it empty the underrun fires and the write still loads.
        if (xfer) begin
            if (hold_full_q) begin
                tx_l_d      = hold_l_q;
                tx_r_d      = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (iADC_WR && !hold_full_q) begin
            hold_l_d    = iADC_L;
            hold_r_d    = iADC_R;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_SYNC;
            lrck_q      <= 1'b0;
            primed_q    <= 1'b0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            pend_l_q    <= '0;
            left_ok_q   <= 1'b0;
            dac_l_q     <= '0;
            dac_r_q     <= '0;
            dac_valid_q <= 1'b0;
            slot_err_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
        end else begin
            state_q     <= state_d;
            lrck_q      <= lrck_d;
            primed_q    <= primed_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            pend_l_q    <= pend_l_d;
            left_ok_q   <= left_ok_d;
            dac_l_q     <= dac_l_d;
            dac_r_q     <= dac_r_d;
            dac_valid_q <= dac_valid_d;
            slot_err_q  <= slot_err_d;
            underrun_q  <= underrun_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
        end
    end

    // At the falling edge iLRCK already shows the new slot while lrck_q does not,
    // so the MSB is launched half a cycle before the master samples it.
    always_comb begin
        tx_word    = iLRCK ? tx_l_q : tx_r_q;
        tx_shifted = tx_word << txcnt_q;
        adcdat_d   = 1'b0;
        txcnt_d    = txcnt_q;
        if (lrck_edge) begin
            adcdat_d = tx_word[DATA_WIDTH-1];
            txcnt_d  = TXC_W'(1);
        end else if (txcnt_q < TXC_WORD) begin
            adcdat_d = tx_shifted[DATA_WIDTH-1];
            txcnt_d  = txcnt_q + TXC_W'(1);
        end
    end

    always_ff @(negedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            adcdat_q <= 1'b0;
            txcnt_q  <= TXC_WORD;
        end else begin
            adcdat_q <= adcdat_d;
            txcnt_q  <= txcnt_d;
        end
    end

    assign oADCDAT       = adcdat_q;
    assign oADC_RDY      = !hold_full_q;
    assign oADC_UNDERRUN = underrun_q;
    assign oDAC_L        = dac_l_q;
    assign oDAC_R        = dac_r_q;
    assign oDAC_VALID    = dac_valid_q;
    assign oSLOT_ERR     = slot_err_q;

endmodule

// File: tb/tb_audio_codec_slave.sv
// Directed bench for audio_codec_slave: the bench plays the audio master,
// sending DACDAT frames and capturing ADCDAT MSB-first on rising edges.
module tb_audio_codec_slave;

    logic        BCLK;
    logic        iRST_N;
    logic        iLRCK;
    logic        iDACDAT;
    logic        oADCDAT;
    logic [15:0] iADC_L;
    logic [15:0] iADC_R;
    logic        iADC_WR;
    logic        oADC_RDY;
    logic        oADC_UNDERRUN;
    logic [15:0] oDAC_L;
    logic [15:0] oDAC_R;
    logic        oDAC_VALID;
    logic        oSLOT_ERR;

    int          checks = 0;
    int          errors = 0;
    int          validTotal = 0;
    int          underrunTotal = 0;
    int          slotErrTotal = 0;
    logic        rdyAtValid = 1'b0;
    int          validBase, underrunBase, slotErrBase;
    logic [15:0] slotCap, capL, capR;

    audio_codec_slave #(.DATA_WIDTH(16), .SLOT_BITS(32)) dut (
        .BCLK(BCLK), .iRST_N(iRST_N), .iLRCK(iLRCK), .iDACDAT(iDACDAT),
        .oADCDAT(oADCDAT), .iADC_L(iADC_L), .iADC_R(iADC_R), .iADC_WR(iADC_WR),
        .oADC_RDY(oADC_RDY), .oADC_UNDERRUN(oADC_UNDERRUN), .oDAC_L(oDAC_L),
        .oDAC_R(oDAC_R), .oDAC_VALID(oDAC_VALID), .oSLOT_ERR(oSLOT_ERR)
    );

    initial BCLK = 1'b0;
    always #5 BCLK = ~BCLK;

    // Pulses are counted on falling edges, so a stuck-high pulse inflates its count.
    always @(negedge BCLK) begin
        if (oDAC_VALID) begin
            validTotal = validTotal + 1;
            rdyAtValid = oADC_RDY;
        end
        if (oADC_UNDERRUN) underrunTotal = underrunTotal + 1;
        if (oSLOT_ERR) slotErrTotal = slotErrTotal + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives slot indices first..last-1; iADC_WR is held for three bits from wrAt.
    task automatic sendSlot(input logic lrck, input logic [15:0] word,
                            input int first, input int last, input int wrAt);
        logic [15:0] sh;
        for (int i = first; i < last; i++) begin
            #1;
            sh      = word << i;
            iLRCK   = lrck;
            iDACDAT = sh[15];
            iADC_WR = (wrAt >= 0) && (i >= wrAt) && (i < wrAt + 3);
            if (i == wrAt)     begin iADC_L = 16'hBEEF; iADC_R = 16'hCAFE; end
            if (i == wrAt + 1) begin iADC_L = 16'h1111; iADC_R = 16'h2222; end
            if (i == wrAt + 2) begin iADC_L = 16'h3333; iADC_R = 16'h4444; end
            @(posedge BCLK);
            if (i < 16) slotCap = {slotCap[14:0], oADCDAT};
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r,
                                 input int rbits, input int wrAt);
        validBase    = validTotal;
        underrunBase = underrunTotal;
        slotErrBase  = slotErrTotal;
        sendSlot(1'b1, l, 0, 32, -1);
        capL = slotCap;
        sendSlot(1'b0, r, 0, rbits, wrAt);
        capR = slotCap;
        #1;
    endtask

    task automatic writeAdc(input logic [15:0] l, input logic [15:0] r);
        #1;
        iADC_L  = l;
        iADC_R  = r;
        iADC_WR = 1'b1;
        @(posedge BCLK);
        #1;
        iADC_WR = 1'b0;
        @(posedge BCLK);
        #1;
    endtask

    initial begin
        iRST_N  = 1'b0;
        iLRCK   = 1'b0;
        iDACDAT = 1'b0;
        iADC_L  = '0;
        iADC_R  = '0;
        iADC_WR = 1'b0;
        slotCap = '0;
        repeat (3) @(posedge BCLK);
        #1;
        checkOutput("rst_adcdat",   32'(oADCDAT),       32'h0);
        checkOutput("rst_dac_l",    32'(oDAC_L),        32'h0);
        checkOutput("rst_dac_r",    32'(oDAC_R),        32'h0);
        checkOutput("rst_valid",    32'(oDAC_VALID),    32'h0);
        checkOutput("rst_rdy",      32'(oADC_RDY),      32'h1);
        checkOutput("rst_underrun", 32'(oADC_UNDERRUN), 32'h0);
        checkOutput("rst_slot_err", 32'(oSLOT_ERR),     32'h0);
        @(posedge BCLK);
        #1 iRST_N = 1'b1;
        repeat (3) @(posedge BCLK);

        writeAdc(16'h1234, 16'hABCD);
        checkOutput("wr1_rdy_low", 32'(oADC_RDY), 32'h0);
        @(posedge BCLK);

        // First frame out of SYNC publishes; ADCDAT still carries the reset pair.
        applyStimulus(16'h6000, 16'hA000, 32, -1);
        checkOutput("f1_valid",    32'(validTotal - validBase),       32'd1);
        checkOutput("f1_dac_l",    32'(oDAC_L),                       32'h6000);
        checkOutput("f1_dac_r",    32'(oDAC_R),                       32'hA000);
        checkOutput("f1_cap_l",    32'(capL),                         32'h0000);
        checkOutput("f1_cap_r",    32'(capR),                         32'h0000);
        checkOutput("f1_underrun", 32'(underrunTotal - underrunBase), 32'd0);
        checkOutput("f1_rdy_xfer", 32'(rdyAtValid),                   32'h1);

        applyStimulus(16'h6000, 16'hA000, 32, -1);
        checkOutput("f2_cap_l",    32'(capL),                         32'h1234);
        checkOutput("f2_cap_r",    32'(capR),                         32'hABCD);
        checkOutput("f2_underrun", 32'(underrunTotal - underrunBase), 32'd1);
        checkOutput("f2_valid",    32'(validTotal - validBase),       32'd1);
        checkOutput("f2_dac_l",    32'(oDAC_L),                       32'h6000);

        applyStimulus(16'h6000, 16'hA000, 32, -1);
        checkOutput("f3_cap_l",    32'(capL),                         32'h1234);
        checkOutput("f3_cap_r",    32'(capR),                         32'hABCD);
        checkOutput("f3_underrun", 32'(underrunTotal - underrunBase), 32'd1);

        // Right slot cut to 10 bits: no publish, no transfer point.
        applyStimulus(16'h1111, 16'h2222, 10, -1);
        checkOutput("f4_valid",    32'(validTotal - validBase),       32'd0);
        checkOutput("f4_dac_l",    32'(oDAC_L),                       32'h6000);
        checkOutput("f4_dac_r",    32'(oDAC_R),                       32'hA000);
        checkOutput("f4_underrun", 32'(underrunTotal - underrunBase), 32'd0);
        checkOutput("f4_slot_err", 32'(slotErrTotal - slotErrBase),   32'd0);

        applyStimulus(16'h0F0F, 16'hF0F0, 32, -1);
        checkOutput("f5_slot_err", 32'(slotErrTotal - slotErrBase),   32'd1);
        checkOutput("f5_valid",    32'(validTotal - validBase),       32'd1);
        checkOutput("f5_dac_l",    32'(oDAC_L),                       32'h0F0F);
        checkOutput("f5_dac_r",    32'(oDAC_R),                       32'hF0F0);
        checkOutput("f5_underrun", 32'(underrunTotal - underrunBase), 32'd1);

        writeAdc(16'h9999, 16'h8888);
        checkOutput("wr2_rdy_low", 32'(oADC_RDY), 32'h0);
        @(posedge BCLK);

        // Reset lands right after left bit 7 has been sampled.
        sendSlot(1'b1, 16'h7777, 0, 8, -1);
        #2 iRST_N = 1'b0;
        #1;
        checkOutput("mid_rst_adcdat",   32'(oADCDAT),       32'h0);
        checkOutput("mid_rst_dac_l",    32'(oDAC_L),        32'h0);
        checkOutput("mid_rst_dac_r",    32'(oDAC_R),        32'h0);
        checkOutput("mid_rst_valid",    32'(oDAC_VALID),    32'h0);
        checkOutput("mid_rst_rdy",      32'(oADC_RDY),      32'h1);
        checkOutput("mid_rst_underrun", 32'(oADC_UNDERRUN), 32'h0);
        checkOutput("mid_rst_slot_err", 32'(oSLOT_ERR),     32'h0);
        @(posedge BCLK);
        @(posedge BCLK);
        #1 iRST_N = 1'b1;
        validBase   = validTotal;
        slotErrBase = slotErrTotal;
        sendSlot(1'b1, 16'h7777, 8, 32, -1);
        sendSlot(1'b0, 16'h1357, 0, 32, -1);
        #1;
        checkOutput("post_rst_valid",    32'(validTotal - validBase),     32'd0);
        checkOutput("post_rst_slot_err", 32'(slotErrTotal - slotErrBase), 32'd0);

        // Write held three cycles: first loads, the last coincides with the transfer.
        applyStimulus(16'h5A5A, 16'hC3C3, 32, 13);
        checkOutput("f7_valid",    32'(validTotal - validBase),       32'd1);
        checkOutput("f7_dac_l",    32'(oDAC_L),                       32'h5A5A);
        checkOutput("f7_dac_r",    32'(oDAC_R),                       32'hC3C3);
        checkOutput("f7_underrun", 32'(underrunTotal - underrunBase), 32'd0);
        checkOutput("f7_rdy",      32'(oADC_RDY),                     32'h1);

        applyStimulus(16'h8001, 16'h7FFE, 32, -1);
        checkOutput("f8_cap_l",    32'(capL),                         32'hBEEF);
        checkOutput("f8_cap_r",    32'(capR),                         32'hCAFE);
        checkOutput("f8_valid",    32'(validTotal - validBase),       32'd1);
        checkOutput("f8_dac_l",    32'(oDAC_L),                       32'h8001);
        checkOutput("f8_dac_r",    32'(oDAC_R),                       32'h7FFE);
        checkOutput("f8_underrun", 32'(underrunTotal - underrunBase), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_codec_slave.md
# audio_codec_slave

Codec-side end of the 16-bit left-justified serial audio link driven by the FPGA audio master. Runs entirely in the BCLK domain. It deserialises DACDAT into parallel left/right pairs. It also serialises parallel ADC pairs onto ADCDAT, aligned to the master's LRCK. It serves as an on-chip loopback/cassette-model endpoint and as the verification counterpart of the master interface.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel word, MSB first
- SLOT_BITS, 32, saturation value of the per-slot bit counter

Ports:
- BCLK  in  1  bit clock; reset iRST_N, asynchronous, active-low; clock BCLK
- iRST_N  in  1  asynchronous active-low reset
- iLRCK  in  1  channel select: 1 = left slot, 0 = right slot
- iDACDAT  in  1  serial playback data from master
- oADCDAT  out  1  serial capture data to master
- iADC_L, iADC_R  in  DATA_WIDTH  parallel capture pair to transmit
- iADC_WR  in  1  write strobe for the iADC pair
- oADC_RDY  out  1  holding register empty; iADC_WR accepted only when 1
- oADC_UNDERRUN  out  1  1-cycle pulse: transfer point reached with holding register empty
- oDAC_L, oDAC_R  out  DATA_WIDTH  last complete received pair
- oDAC_VALID  out  1  1-cycle pulse: new oDAC pair published
- oSLOT_ERR  out  1  1-cycle pulse: slot ended before DATA_WIDTH bits

## Operation
- Link rules: the master changes LRCK/DACDAT after the BCLK rising edge. This block samples on the rising edge. oADCDAT is launched on the falling edge; this is the only negedge register.
- lrck_d = iLRCK registered on posedge. edge = (iLRCK != lrck_d). The posedge where edge=1 samples bit index 0 (MSB) of the new slot.
- Receive FSM (posedge): SYNC, LEFT, RIGHT.
  - SYNC: DACDAT ignored. On edge: go to LEFT if iLRCK=1, else RIGHT.
  - LEFT/RIGHT: on edge, shift in iDACDAT, bitcnt<=1, and switch state per iLRCK.
  - No edge and bitcnt<DATA_WIDTH: shift, bitcnt++. bitcnt saturates at SLOT_BITS. Bits beyond DATA_WIDTH are ignored.
- Word completion is the posedge capturing index DATA_WIDTH-1.
  - LEFT completion: pend_l <= word, left_ok <= 1.
  - RIGHT completion with left_ok=1: oDAC_L <= pend_l, oDAC_R <= word, oDAC_VALID=1 next cycle, left_ok <= 0. This is also the tx transfer point.
  - RIGHT completion with left_ok=0: word discarded; the transfer point still occurs.
- Short slot: edge in LEFT/RIGHT with bitcnt<DATA_WIDTH pulses oSLOT_ERR and discards the partial word. If it occurs in RIGHT, there is no transfer point. If it occurs in LEFT, left_ok <= 0. The new slot still starts normally on that edge.
- Transmit holding register: iADC_WR with oADC_RDY=1 loads hold_l/hold_r and clears oADC_RDY. iADC_WR with oADC_RDY=0 is ignored.
- At the transfer point:
  - hold full: tx_l/tx_r <= hold and oADC_RDY <= 1.
  - hold empty: tx pair unchanged, oADC_UNDERRUN pulses.
- Transmit (negedge):
  - If iLRCK != lrck_d: oADCDAT <= (iLRCK ? tx_l : tx_r)[DATA_WIDTH-1], txcnt <= 1.
  - Else if txcnt<DATA_WIDTH: output bit [DATA_WIDTH-1-txcnt], txcnt++.
  - Else: oADCDAT <= 0.
  - The transmitter launches in every state, including SYNC.

## Timing
- Reset values: oADCDAT 0, oDAC_L/R 0, oDAC_VALID 0, oADC_RDY 1, oADC_UNDERRUN 0, oSLOT_ERR 0. Internal reset: tx_l/tx_r 0, hold empty, left_ok 0, state SYNC.
- Reset mid-frame drops all partial and pending data. The block resyncs on the next LRCK edge, and the first pair published needs a full left slot then a full right slot.
- Receive latency: oDAC_VALID is high in the cycle after the posedge sampling right bit 15. The oDAC pair is stable from that cycle until the next publish.
- oADC_RDY rises 1 cycle after the transfer point.
- Simultaneous iADC_WR and transfer:
  - hold full: the transfer takes the old hold and the write is ignored.
  - hold empty: underrun fires, then the write loads hold.
- Pulse outputs are exactly 1 BCLK wide.

## Test plan
- Master sends L=16'h6000, R=16'hA000, 32-bit slots, after reset → oDAC_VALID pulses once per frame, oDAC_L=6000, oDAC_R=A000; first frame after reset begins in SYNC, so publish starts on the first full L+R.
- iADC pair 16'h1234/16'hABCD written before first transfer point → following frame master captures L=1234, R=ABCD MSB-first on posedges index 0..15; oADC_RDY returns to 1 one cycle after transfer.
- No iADC_WR for two frames → oADC_UNDERRUN pulses at each right completion; ADCDAT repeats the last pair (0000/0000 after reset).
- Right slot cut to 10 bits → oSLOT_ERR pulses at the edge; no oDAC_VALID that frame; oDAC holds previous values; next full frame publishes correctly.
- iRST_N asserted at left bit 7 and released → all outputs at reset values immediately; first oDAC_VALID only after the next complete left+right pair.
- iADC_WR held high for 3 cycles with hold full, landing on the transfer cycle → only the first write is taken; the transmitted pair equals the first write.
